route_cfg_ctrl: RTL and testbench
=================================

Name: route_cfg_ctrl

Overview:
- Conditions the 16 board slide switches and owns the committed pin-routing configuration used by the Nexys4 top-level pin muxes (SW12–SW15).
- Replaces direct use of debounced switches for routing: routing changes are grouped, committed atomically, and accompanied by a core reset request, so the Propeller never runs across a half-applied pin remap.
- Sits between the raw switch pins and the top-level mux logic; core_res is ORed into the reset block's async_res path by the top level.

Parameters:
- WIDTH, 16: number of switch inputs.
- SYNC_STAGES, 2: synchronizer flops per bit; minimum 2.
- DB_CYCLES, 50000: consecutive cycles a synchronized bit must differ from switch_db before switch_db flips.
- SETTLE_CYCLES, 100000: quiet period after the last routing-bit change before commit.
- RST_PULSE, 64: core_res high time, in cycles.
- ROUTE_MASK, 16'hF000: bits whose change requires commit plus reset.

Ports:
- clock  in  1  slow_clk domain.
- nres  in  1  asynchronous active-low reset.
- switch  in  WIDTH  raw asynchronous switch levels.
- switch_db  out  WIDTH  debounced switch levels.
- route_cfg  out  WIDTH  committed configuration consumed by the pin muxes.
- cfg_change  out  1  one-cycle pulse on each routing commit.
- core_res  out  1  active-high core reset request.
- busy  out  1  high in SETTLE or RESET.

Behaviour:
- Reset (nres low, asynchronous): all synchronizer flops, switch_db, route_cfg, counters, cfg_change, core_res and busy go to 0; FSM goes to IDLE.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit.
- Debounce, per bit, with an independent counter of width $clog2(DB_CYCLES+1):
  - If the synced bit equals switch_db, the counter clears.
  - Otherwise the counter increments; when it reaches DB_CYCLES, switch_db toggles and the counter clears.
  - A raw step held stable appears on switch_db exactly SYNC_STAGES+DB_CYCLES cycles later.
  - A glitch shorter than DB_CYCLES synced cycles never appears on switch_db.
- Non-routing bits (~ROUTE_MASK): route_cfg follows switch_db with 1-cycle latency in all states; no reset is requested.
- Routing bits (ROUTE_MASK) change only at commit. Let diff = (switch_db ^ route_cfg) & ROUTE_MASK.
- FSM state IDLE:
  - busy=0, core_res=0.
  - If diff != 0, clear the settle counter and go to SETTLE.
- FSM state SETTLE:
  - busy=1.
  - Any change of masked switch_db bits versus the previous cycle clears the settle counter.
  - If diff becomes 0 (switch returned), go to IDLE with no commit and no pulse.
  - When the settle counter reaches SETTLE_CYCLES, commit: route_cfg[mask] <= switch_db[mask], cfg_change=1 for that single cycle, go to RESET.
- FSM state RESET:
  - core_res=1 and busy=1 for exactly RST_PULSE cycles, starting the cycle after commit, then go to IDLE.
  - Switch changes during RESET are not committed; diff is re-evaluated on return to IDLE.
- Power-up: route_cfg starts at 0, the default demo-board routing. Switches already on at reset debounce in and trigger one normal commit and reset sequence.
- Asserting nres mid-SETTLE or mid-RESET aborts immediately: core_res=0 and route_cfg=0.
- All outputs are registered; no combinational path from switch to any output.

Decomposition:
- Shared package route_pkg:
  - state enum {IDLE, SETTLE, RESET}.
  - default ROUTE_MASK constant.
  - named bit indices SW_PS2=12, SW_VGA=13, SW_AUDIO=14, SW_PROPPLUG=15.
- Sub-module sw_debounce_bit (synchronizer plus counter for one bit), generated WIDTH times.
- FSM, settle counter and pulse counter stay in route_cfg_ctrl.

Test Plan (all scenarios use DB_CYCLES=4, SETTLE_CYCLES=8, RST_PULSE=3):
- Non-routing bit: raw switch[0] steps 0->1 -> switch_db[0]=1 exactly 6 cycles later, route_cfg[0]=1 one cycle after that; core_res and cfg_change stay 0.
- Glitch rejection: raw switch[5] pulses high for 3 cycles -> switch_db stays 16'h0000; all counters return to 0.
- Routing commit: switch[13] steps to 1 and holds -> busy rises, cfg_change pulses once 8 cycles after switch_db[13] rises, route_cfg=16'h2000, core_res high for exactly 3 cycles, then IDLE with busy=0.
- Grouping: switch[12] and then switch[15] change 5 cycles apart -> a single cfg_change, route_cfg=16'h9000, one 3-cycle core_res.
- Revert in SETTLE: switch[14] goes to 1 then returns to 0 before the settle count ends -> no cfg_change, no core_res, route_cfg unchanged, FSM back in IDLE.
- Reset mid-RESET: assert nres low during the second core_res cycle -> all outputs 0 asynchronously; after release with switch[15]=1, one full commit sequence recurs.

Source files
------------

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
// Module      : route_pkg
// Description : Shared state encoding and routing-switch constants.
// Revision    : 1.0 - initial release
// ============================================================================
package route_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESET  = 2'd2
    } route_state_t;

    localparam int unsigned SW_PS2      = 12;
    localparam int unsigned SW_VGA      = 13;
    localparam int unsigned SW_AUDIO    = 14;
    localparam int unsigned SW_PROPPLUG = 15;

    localparam logic [15:0] ROUTE_MASK_DEFAULT =
        16'((32'd1 << SW_PS2) | (32'd1 << SW_VGA) |
            (32'd1 << SW_AUDIO) | (32'd1 << SW_PROPPLUG));

endpackage
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_bit
// Description : Synchronizer chain plus persistence counter for one switch.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_bit
    import route_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000
) (
    input  logic clock,
    input  logic nres,
    input  logic raw,
    output logic db
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_db;

    // Toggle on the DB_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge clock or negedge nres) begin
        if (!nres) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
            if (r_sync[SYNC_STAGES-1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/route_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : route_cfg_ctrl
// Description : Debounces board switches and commits pin-routing changes
//               atomically, requesting a core reset on each commit.
// Revision    : 1.0 - initial release
// ============================================================================
module route_cfg_ctrl
    import route_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter int               SYNC_STAGES   = 2,
    parameter int               DB_CYCLES     = 50000,
    parameter int               SETTLE_CYCLES = 100000,
    parameter int               RST_PULSE     = 64,
    parameter logic [WIDTH-1:0] ROUTE_MASK    = WIDTH'(ROUTE_MASK_DEFAULT)
) (
    input  logic             clock,
    input  logic             nres,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_db,
    output logic [WIDTH-1:0] route_cfg,
    output logic             cfg_change,
    output logic             core_res,
    output logic             busy
);

    localparam int                   c_SET_W      = $clog2(SETTLE_CYCLES + 1);
    localparam int                   c_PUL_W      = $clog2(RST_PULSE + 1);
    // The clearing edge is itself the first quiet cycle of the window.
    localparam logic [c_SET_W-1:0]   c_SET_LAST   = c_SET_W'(SETTLE_CYCLES - 2);
    localparam logic [c_PUL_W-1:0]   c_PUL_LAST   = c_PUL_W'(RST_PULSE - 1);

    logic [WIDTH-1:0]   w_db;
    logic [WIDTH-1:0]   w_diff;
    logic               w_masked_chg;

    route_state_t       r_state;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic [c_PUL_W-1:0] r_pulse_cnt;
    logic [WIDTH-1:0]   r_prev_db;
    logic [WIDTH-1:0]   r_route_cfg;
    logic               r_cfg_change;
    logic               r_core_res;
    logic               r_busy;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_db (
            .clock (clock),
            .nres  (nres),
            .raw   (switch[gi]),
            .db    (w_db[gi])
        );
    end

    assign w_diff       = (w_db ^ r_route_cfg) & ROUTE_MASK;
    assign w_masked_chg = |((w_db ^ r_prev_db) & ROUTE_MASK);

    always_ff @(posedge clock or negedge nres) begin
        if (!nres) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_pulse_cnt  <= '0;
            r_prev_db    <= '0;
            r_route_cfg  <= '0;
            r_cfg_change <= 1'b0;
            r_core_res   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_prev_db    <= w_db;
            r_cfg_change <= 1'b0;
            r_route_cfg  <= (w_db & ~ROUTE_MASK) | (r_route_cfg & ROUTE_MASK);
            case (r_state)
                IDLE: begin
                    if (|w_diff) begin
                        r_settle_cnt <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (~|w_diff) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_masked_chg) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == c_SET_LAST) begin
                        r_route_cfg  <= w_db;
                        r_cfg_change <= 1'b1;
                        r_core_res   <= 1'b1;
                        r_pulse_cnt  <= '0;
                        r_state      <= RESET;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                RESET: begin
                    if (r_pulse_cnt == c_PUL_LAST) begin
                        r_core_res <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    r_core_res <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign switch_db  = w_db;
    assign route_cfg  = r_route_cfg;
    assign cfg_change = r_cfg_change;
    assign core_res   = r_core_res;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_route_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_cfg_ctrl
// Description : Vector table, corner sequences and random run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_cfg_ctrl;

    localparam int          c_DB     = 4;
    localparam int          c_SETTLE = 8;
    localparam int          c_RST    = 3;
    localparam logic [15:0] c_MASK   = 16'hF000;

    logic        clock;
    logic        nres;
    logic [15:0] sw;
    logic [15:0] switch_db;
    logic [15:0] route_cfg;
    logic        cfg_change;
    logic        core_res;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_chg;
    int n_res;

    route_cfg_ctrl #(
        .WIDTH         (16),
        .SYNC_STAGES   (2),
        .DB_CYCLES     (c_DB),
        .SETTLE_CYCLES (c_SETTLE),
        .RST_PULSE     (c_RST),
        .ROUTE_MASK    (c_MASK)
    ) dut (
        .clock      (clock),
        .nres       (nres),
        .switch     (sw),
        .switch_db  (switch_db),
        .route_cfg  (route_cfg),
        .cfg_change (cfg_change),
        .core_res   (core_res),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: timestamps of masked switch changes drive the commit.
    logic [15:0] m_q[$];
    logic [15:0] m_db, m_route;
    int          m_run[16];
    int          m_phase;
    int          m_k, m_entry, m_last_chg, m_reset_end;
    logic        m_chg, m_res, m_busy;

    function automatic void model_reset();
        m_q        = '{16'h0000, 16'h0000};
        m_db       = '0;
        m_route    = '0;
        for (int b = 0; b < 16; b++) m_run[b] = 0;
        m_phase    = 0;
        m_k        = 0;
        m_entry    = 0;
        m_last_chg = -100;
        m_reset_end = 0;
        m_chg      = 1'b0;
        m_res      = 1'b0;
        m_busy     = 1'b0;
    endfunction

    function automatic void model_step(logic [15:0] raw);
        logic [15:0] s, diff, db_pre;
        int deadline;
        m_k++;
        db_pre = m_db;
        diff   = (db_pre ^ m_route) & c_MASK;
        m_chg  = 1'b0;
        if (m_phase == 0) begin
            if (diff != 0) begin
                m_phase = 1;
                m_entry = m_k;
            end
        end else if (m_phase == 1) begin
            deadline = (((m_entry - 1) > m_last_chg) ? (m_entry - 1) : m_last_chg) + c_SETTLE;
            if (diff == 0) begin
                m_phase = 0;
            end else if (m_k == deadline) begin
                m_route     = (m_route & ~c_MASK) | (db_pre & c_MASK);
                m_chg       = 1'b1;
                m_phase     = 2;
                m_reset_end = m_k + c_RST;
            end
        end else if (m_k == m_reset_end) begin
            m_phase = 0;
        end
        m_route = (m_route & c_MASK) | (db_pre & ~c_MASK);
        m_res   = (m_phase == 2);
        m_busy  = (m_phase != 0);
        s = m_q.pop_front();
        m_q.push_back(raw);
        for (int b = 0; b < 16; b++) begin
            if (s[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == c_DB) begin
                    m_db[b]  = ~m_db[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        if (((m_db ^ db_pre) & c_MASK) != 0) m_last_chg = m_k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [15:0] raw;
        raw = sw;
        @(posedge clock);
        #1;
        model_step(raw);
        check("model", {switch_db, route_cfg, cfg_change, core_res, busy},
              {m_db, m_route, m_chg, m_res, m_busy});
        if (cfg_change) n_chg++;
        if (core_res) n_res++;
    endtask

    task automatic async_reset(input logic [15:0] sw_after);
        #2 nres = 1'b0;
        model_reset();
        #1;
        check("async_clear", {switch_db, route_cfg, cfg_change, core_res, busy}, '0);
        sw = sw_after;
        repeat (3) @(posedge clock);
        #1 nres = 1'b1;
    endtask

    typedef struct {
        logic [15:0] sw;
        int          n;
        logic [15:0] db;
        logic [15:0] route;
        int          nchg;
        int          nres;
        logic        busy;
    } vec_t;

    vec_t vecs[21];

    initial begin
        bit found;

        vecs[0]  = '{16'h0001, 6,  16'h0001, 16'h0000, 0, 0, 1'b0};
        vecs[1]  = '{16'h0001, 1,  16'h0001, 16'h0001, 0, 0, 1'b0};
        vecs[2]  = '{16'h0021, 3,  16'h0001, 16'h0001, 0, 0, 1'b0};
        vecs[3]  = '{16'h0001, 6,  16'h0001, 16'h0001, 0, 0, 1'b0};
        vecs[4]  = '{16'h0021, 1,  16'h0001, 16'h0001, 0, 0, 1'b0};
        vecs[5]  = '{16'h0001, 8,  16'h0001, 16'h0001, 0, 0, 1'b0};
        vecs[6]  = '{16'h2001, 6,  16'h2001, 16'h0001, 0, 0, 1'b0};
        vecs[7]  = '{16'h2001, 7,  16'h2001, 16'h0001, 0, 0, 1'b1};
        vecs[8]  = '{16'h2001, 1,  16'h2001, 16'h2001, 1, 1, 1'b1};
        vecs[9]  = '{16'h2001, 3,  16'h2001, 16'h2001, 0, 2, 1'b0};
        vecs[10] = '{16'h3001, 5,  16'h2001, 16'h2001, 0, 0, 1'b0};
        vecs[11] = '{16'hB001, 1,  16'h3001, 16'h2001, 0, 0, 1'b0};
        vecs[12] = '{16'hB001, 5,  16'hB001, 16'h2001, 0, 0, 1'b1};
        vecs[13] = '{16'hB001, 7,  16'hB001, 16'h2001, 0, 0, 1'b1};
        vecs[14] = '{16'hB001, 1,  16'hB001, 16'hB001, 1, 1, 1'b1};
        vecs[15] = '{16'hB001, 3,  16'hB001, 16'hB001, 0, 2, 1'b0};
        vecs[16] = '{16'hF001, 6,  16'hF001, 16'hB001, 0, 0, 1'b0};
        vecs[17] = '{16'hF001, 1,  16'hF001, 16'hB001, 0, 0, 1'b1};
        vecs[18] = '{16'hB001, 6,  16'hB001, 16'hB001, 0, 0, 1'b1};
        vecs[19] = '{16'hB001, 1,  16'hB001, 16'hB001, 0, 0, 1'b0};
        vecs[20] = '{16'hB001, 10, 16'hB001, 16'hB001, 0, 0, 1'b0};

        nres = 1'b1;
        sw   = '0;
        model_reset();
        #2 nres = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {switch_db, route_cfg, cfg_change, core_res, busy}, '0);
        nres = 1'b1;

        for (int v = 0; v < 21; v++) begin
            sw    = vecs[v].sw;
            n_chg = 0;
            n_res = 0;
            repeat (vecs[v].n) tick();
            check($sformatf("v%0d_db", v),    switch_db, vecs[v].db);
            check($sformatf("v%0d_route", v), route_cfg, vecs[v].route);
            check($sformatf("v%0d_chg", v),   n_chg,     vecs[v].nchg);
            check($sformatf("v%0d_res", v),   n_res,     vecs[v].nres);
            check($sformatf("v%0d_busy", v),  busy,      vecs[v].busy);
        end

        // Abort during the second core_res cycle, then recover with SW15 on.
        sw    = 16'h0000;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (cfg_change) found = 1'b1;
        end
        check("commit_seen", found, 1'b1);
        tick();
        check("res_2nd_cycle", core_res, 1'b1);
        async_reset(16'h8000);
        n_chg = 0;
        n_res = 0;
        repeat (30) tick();
        check("rec_db",    switch_db, 16'h8000);
        check("rec_route", route_cfg, 16'h8000);
        check("rec_chg",   n_chg,     1);
        check("rec_res",   n_res,     3);
        check("rec_busy",  busy,      1'b0);

        for (int seg = 0; seg < 220; seg++) begin
            int unsigned r;
            int unsigned idx;
            if (seg == 110) async_reset(16'(($urandom_range(0, 15)) << 12));
            r = $urandom_range(0, 9);
            if (r < 4) begin
                idx = $urandom_range(12, 15);
                sw[idx] = ~sw[idx];
            end else if (r < 7) begin
                idx = $urandom_range(0, 11);
                sw[idx] = ~sw[idx];
            end else if (r < 9) begin
                idx = $urandom_range(0, 15);
                sw[idx] = ~sw[idx];
                repeat ($urandom_range(1, 5)) tick();
                sw[idx] = ~sw[idx];
            end
            repeat ($urandom_range(1, 20)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
